inst_encoder: RTL and testbench

Pipelined RISC-V instruction encoder: the inverse of the immediate extender. Takes a format select, opcode, register/funct fields and a 32-bit immediate, checks that the immediate is encodable in that format, and emits the packed 32-bit instruction word. It sits between the debug/boot loader command path and instruction-memory write logic. It has valid/ready handshakes on both sides, a 2-stage pipeline, and saturating good/error counters.

---
 rtl/inst_encoder.sv | 173 +++++++++++++++++
 tb/tb_inst_encoder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// inst_encoder: pipelined RISC-V instruction encoder (inverse of the immediate
// extender). Checks that an immediate is encodable in the selected format and
// packs opcode, register, funct3 and immediate fields into a 32-bit word.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     request handshake
//   in_fmt                001 I, 011 S, 100 B, 101 U, 110 J (others illegal)
//   in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm   request fields
//   out_valid/out_ready   result handshake
//   out_inst              encoded word (0 on error)
//   out_err, out_err_code error flag; 00 ok, 01 range, 10 misaligned, 11 bad fmt
//   enc_count, err_count  saturating counts of delivered good / error results
module inst_encoder #(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_fmt,
    input  logic [6:0]         in_opcode,
    input  logic [4:0]         in_rd,
    input  logic [4:0]         in_rs1,
    input  logic [4:0]         in_rs2,
    input  logic [2:0]         in_funct3,
    input  logic [31:0]        in_imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_inst,
    output logic               out_err,
    output logic [1:0]         out_err_code,
    output logic [COUNT_W-1:0] enc_count,
    output logic [COUNT_W-1:0] err_count
);

    typedef enum logic [2:0] {
        FMT_I = 3'b001,
        FMT_S = 3'b011,
        FMT_B = 3'b100,
        FMT_U = 3'b101,
        FMT_J = 3'b110
    } fmt_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_RANGE = 2'b01,
        ERR_ALIGN = 2'b10,
        ERR_FMT   = 2'b11
    } err_e;

    // Stage 1 state
    logic        s1_valid;
    fmt_e        s1_fmt;
    err_e        s1_err;
    logic [6:0]  s1_opcode;
    logic [4:0]  s1_rd, s1_rs1, s1_rs2;
    logic [2:0]  s1_funct3;
    logic [31:0] s1_imm;

    logic        s1_load, s2_load;
    err_e        chk_err;
    logic        bad_fmt, misaligned, out_of_range;
    logic [31:0] word;

    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = !s1_valid || !out_valid || out_ready;

    // Encodability checks on the incoming request
    always_comb begin
        bad_fmt      = 1'b1;
        misaligned   = 1'b0;
        out_of_range = 1'b0;
        case (fmt_e'(in_fmt))
            FMT_I, FMT_S: begin
                bad_fmt      = 1'b0;
                out_of_range = !((&in_imm[31:11]) || !(|in_imm[31:11]));
            end
            FMT_B: begin
                bad_fmt      = 1'b0;
                misaligned   = in_imm[0];
                out_of_range = !((&in_imm[31:12]) || !(|in_imm[31:12]));
            end
            FMT_U: begin
                bad_fmt      = 1'b0;
                out_of_range = |in_imm[11:0];
            end
            FMT_J: begin
                bad_fmt      = 1'b0;
                misaligned   = in_imm[0];
                out_of_range = !((&in_imm[31:20]) || !(|in_imm[31:20]));
            end
            default: ;
        endcase

        if (bad_fmt)           chk_err = ERR_FMT;
        else if (misaligned)   chk_err = ERR_ALIGN;
        else if (out_of_range) chk_err = ERR_RANGE;
        else                   chk_err = ERR_NONE;
    end

    // Field packing from stage-1 registers
    always_comb begin
        case (s1_fmt)
            FMT_I:   word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
            FMT_S:   word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
            FMT_B:   word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                             s1_imm[4:1], s1_imm[11], s1_opcode};
            FMT_U:   word = {s1_imm[31:12], s1_rd, s1_opcode};
            FMT_J:   word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                             s1_rd, s1_opcode};
            default: word = '0;
        endcase
        if (s1_err != ERR_NONE) word = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_fmt    <= FMT_I;
            s1_err    <= ERR_NONE;
            s1_opcode <= '0;
            s1_rd     <= '0;
            s1_rs1    <= '0;
            s1_rs2    <= '0;
            s1_funct3 <= '0;
            s1_imm    <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_fmt    <= fmt_e'(in_fmt);
                s1_err    <= chk_err;
                s1_opcode <= in_opcode;
                s1_rd     <= in_rd;
                s1_rs1    <= in_rs1;
                s1_rs2    <= in_rs2;
                s1_funct3 <= in_funct3;
                s1_imm    <= in_imm;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_inst     <= '0;
            out_err      <= 1'b0;
            out_err_code <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_inst     <= word;
                out_err      <= (s1_err != ERR_NONE);
                out_err_code <= s1_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_count <= '0;
            err_count <= '0;
        end else if (out_valid && out_ready) begin
            if (out_err) begin
                if (err_count != '1) err_count <= err_count + COUNT_W'(1);
            end else begin
                if (enc_count != '1) enc_count <= enc_count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: table of encode vectors with expected
// words, a scoreboard queue of accepted vector indices, and hand-written
// sequences for latency, backpressure and mid-stream reset.
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic [1:0]  out_err_code;
    logic [15:0] enc_count, err_count;

    inst_encoder #(.COUNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_err(out_err), .out_err_code(out_err_code),
        .enc_count(enc_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [31:0] inst;
        logic        err;
        logic [1:0]  code;
    } vec_t;

    localparam int NV = 16;
    vec_t vt[NV];

    int nvec  = 0;
    int nfail = 0;
    int q[$];
    int cur_idx = 0;
    int m_enc = 0;
    int m_err = 0;

    bit          prev_stall = 0;
    logic [31:0] p_inst;
    logic        p_err;
    logic [1:0]  p_code;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: samples on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("stall_inst", out_inst, p_inst);
                check("stall_err", {31'd0, out_err}, {31'd0, p_err});
                check("stall_code", {30'd0, out_err_code}, {30'd0, p_code});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_out", {31'd0, out_valid}, 32'd0);
                end else begin
                    int k;
                    k = q.pop_front();
                    check($sformatf("inst[%0d]", k), out_inst, vt[k].inst);
                    check($sformatf("err[%0d]", k), {31'd0, out_err}, {31'd0, vt[k].err});
                    check($sformatf("code[%0d]", k), {30'd0, out_err_code}, {30'd0, vt[k].code});
                    if (vt[k].err) m_err++; else m_enc++;
                end
            end
            prev_stall = out_valid && !out_ready;
            p_inst = out_inst;
            p_err  = out_err;
            p_code = out_err_code;
            if (in_valid && in_ready) q.push_back(cur_idx);
        end
    end

    task automatic send(input int idx);
        int  n;
        bit  acc;
        n   = 0;
        acc = 0;
        cur_idx   = idx;
        in_fmt    = vt[idx].fmt;
        in_opcode = vt[idx].op;
        in_rd     = vt[idx].rd;
        in_rs1    = vt[idx].rs1;
        in_rs2    = vt[idx].rs2;
        in_funct3 = vt[idx].f3;
        in_imm    = vt[idx].imm;
        in_valid  = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            nvec++;
            nfail++;
            $display("FAIL accept_timeout: vector %0d not accepted, in_ready=%0b required 1", idx, in_ready);
        end
    endtask

    task automatic drain_and_count();
        int n;
        n = 0;
        in_valid = 1'b0;
        while (q.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_pending", q.size(), 0);
        @(posedge clk);
        #1;
        check("enc_count", {16'd0, enc_count}, m_enc);
        check("err_count", {16'd0, err_count}, m_err);
    endtask

    initial begin
        //           fmt     op      rd     rs1    rs2    f3     imm           inst          err   code
        vt[0]  = '{3'b001, 7'h13, 5'd1,  5'd2,  5'd31, 3'd0, 32'hFFFFFFFF, 32'hFFF10093, 1'b0, 2'b00};
        vt[1]  = '{3'b100, 7'h63, 5'd0,  5'd0,  5'd0,  3'd0, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0, 2'b00};
        vt[2]  = '{3'b100, 7'h63, 5'd0,  5'd0,  5'd0,  3'd0, 32'h00000003, 32'h00000000, 1'b1, 2'b10};
        vt[3]  = '{3'b110, 7'h6F, 5'd1,  5'd0,  5'd0,  3'd0, 32'h00100000, 32'h00000000, 1'b1, 2'b01};
        vt[4]  = '{3'b000, 7'h13, 5'd1,  5'd2,  5'd3,  3'd0, 32'h00000000, 32'h00000000, 1'b1, 2'b11};
        vt[5]  = '{3'b101, 7'h37, 5'd5,  5'd7,  5'd9,  3'd3, 32'h12345000, 32'h123452B7, 1'b0, 2'b00};
        vt[6]  = '{3'b011, 7'h23, 5'd9,  5'd2,  5'd3,  3'd2, 32'h00000004, 32'h00312223, 1'b0, 2'b00};
        vt[7]  = '{3'b011, 7'h23, 5'd0,  5'd2,  5'd3,  3'd2, 32'h00000800, 32'h00000000, 1'b1, 2'b01};
        vt[8]  = '{3'b001, 7'h13, 5'd1,  5'd0,  5'd0,  3'd0, 32'hFFFFF800, 32'h80000093, 1'b0, 2'b00};
        vt[9]  = '{3'b001, 7'h13, 5'd1,  5'd0,  5'd0,  3'd0, 32'h000007FF, 32'h7FF00093, 1'b0, 2'b00};
        vt[10] = '{3'b110, 7'h6F, 5'd1,  5'd0,  5'd0,  3'd0, 32'h00000008, 32'h008000EF, 1'b0, 2'b00};
        vt[11] = '{3'b110, 7'h6F, 5'd1,  5'd0,  5'd0,  3'd0, 32'h00100001, 32'h00000000, 1'b1, 2'b10};
        vt[12] = '{3'b111, 7'h13, 5'd1,  5'd0,  5'd0,  3'd0, 32'h00000001, 32'h00000000, 1'b1, 2'b11};
        vt[13] = '{3'b101, 7'h37, 5'd5,  5'd0,  5'd0,  3'd0, 32'h00000001, 32'h00000000, 1'b1, 2'b01};
        vt[14] = '{3'b100, 7'h63, 5'd0,  5'd0,  5'd0,  3'd0, 32'h00000FFE, 32'h7E000FE3, 1'b0, 2'b00};
        vt[15] = '{3'b100, 7'h63, 5'd0,  5'd0,  5'd0,  3'd0, 32'h00001000, 32'h00000000, 1'b1, 2'b01};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_imm = '0;

        // Reset state
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_out_err", {31'd0, out_err}, 32'd0);
        check("rst_err_code", {30'd0, out_err_code}, 32'd0);
        check("rst_enc_count", {16'd0, enc_count}, 32'd0);
        check("rst_err_count", {16'd0, err_count}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Table vectors, back-to-back at full throughput
        for (int i = 0; i < NV; i++) send(i);
        drain_and_count();

        // Latency: result visible exactly two edges after accept
        send(5);
        in_valid = 1'b0;
        check("lat_k1_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check("lat_k2_valid", {31'd0, out_valid}, 32'd1);
        check("lat_k2_inst", out_inst, 32'h123452B7);
        drain_and_count();

        // Backpressure: three requests with out_ready low for four cycles
        out_ready = 1'b0;
        fork
            begin
                send(0);
                send(1);
                send(2);
                in_valid = 1'b0;
            end
            begin
                repeat (2) @(posedge clk);
                #2;
                check("bp_in_ready", {31'd0, in_ready}, 32'd0);
                check("bp_out_valid", {31'd0, out_valid}, 32'd1);
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain_and_count();

        // Mid-stream reset: in-flight requests are discarded
        cur_idx = 6;
        in_fmt = vt[6].fmt; in_opcode = vt[6].op; in_rd = vt[6].rd;
        in_rs1 = vt[6].rs1; in_rs2 = vt[6].rs2; in_funct3 = vt[6].f3; in_imm = vt[6].imm;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mrst_out_inst", out_inst, 32'd0);
        check("mrst_enc_count", {16'd0, enc_count}, 32'd0);
        check("mrst_err_count", {16'd0, err_count}, 32'd0);
        in_valid = 1'b0;
        q.delete();
        m_enc = 0;
        m_err = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("post_rst_enc_count", {16'd0, enc_count}, 32'd0);
        check("post_rst_err_count", {16'd0, err_count}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
